// File: rtl/div_seq_pkg.sv
// Shared definitions for the sequential radix-2 restoring divider.
package div_seq_pkg;

  // Default operand width and iteration counter width (clog2 of the width).
  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 5;

  // Controller states: idle, iterating, result write-back.
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_FIN  = 2'd2
  } div_state_e;

  // Quotient returned on a divide by zero: all ones.
  localparam logic [DIV_WIDTH-1:0] DIV0_Q = '1;

endpackage : div_seq_pkg

// File: rtl/div_seq_if.sv
// Start/ready handshake bundle between the execute stage and the divider.
interface div_seq_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic               annul;
  logic               sign;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               ready;
  logic [2*WIDTH-1:0] y;

  // Pipeline side issues requests and consumes results.
  modport master (
    output start, annul, sign, a, b,
    input  busy, ready, y
  );

  // Divider side accepts requests and produces {HI, LO}.
  modport slave (
    input  start, annul, sign, a, b,
    output busy, ready, y
  );
endinterface : div_seq_if

// File: rtl/div_seq_step.sv
// One restoring-division step: shift {rem, quo} left, trial-subtract the
// divisor, keep the difference if it did not go negative.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // Shift-subtract-restore; the trial MSB is the borrow of the subtraction.
  always_comb begin
    // NOTE: every output of a combinational block gets a value on every
    // path, otherwise synthesis infers a latch to hold the old value.
    shifted  = {rem, quo[WIDTH-1]};
    trial    = shifted - {1'b0, divisor};
    rem_next = shifted[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      rem_next = trial[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end
  end

endmodule : div_step

// File: rtl/div_seq.sv
// Multi-cycle signed/unsigned divider for MIPS DIV/DIVU producing
// {remainder, quotient} = {HI, LO}. One quotient bit per clock.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic      clk,
  input  logic      rst,
  div_seq_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  div_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   abs_b_q, abs_b_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic               neg_q_q, neg_q_d;
  logic               neg_r_q, neg_r_d;
  logic               busy_q, busy_d;
  logic               ready_q, ready_d;
  logic [2*WIDTH-1:0] y_q, y_d;

  logic [WIDTH-1:0]   step_rem;
  logic [WIDTH-1:0]   step_quo;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (abs_b_q),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  // Operand magnitudes: two's-complement negate only for negative signed inputs.
  always_comb begin
    abs_a = (bus.sign && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    abs_b = (bus.sign && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  end

  // Next-state logic for the controller, datapath and registered outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    abs_b_d = abs_b_q;
    a_raw_d = a_raw_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    ready_d = 1'b0;
    y_d     = y_q;

    unique case (state_q)
      DIV_IDLE: begin
        if (bus.start) begin
          rem_d   = '0;
          quo_d   = abs_a;
          abs_b_d = abs_b;
          a_raw_d = bus.a;
          neg_q_d = bus.sign & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          neg_r_d = bus.sign & bus.a[WIDTH-1];
          cnt_d   = '0;
          // A zero divisor skips the iterations and goes straight to write-back.
          state_d = (bus.b == '0) ? DIV_FIN : DIV_RUN;
        end
      end
      DIV_RUN: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) state_d = DIV_FIN;
      end
      DIV_FIN: begin
        ready_d = 1'b1;
        // |b| is zero only when b itself was zero at accept.
        if (abs_b_q == '0) y_d = {a_raw_q, DIV0_Q[WIDTH-1:0]};
        else               y_d = {neg_r_q ? -rem_q : rem_q,
                                  neg_q_q ? -quo_q : quo_q};
        state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase

    // A flush wins over everything: no accept, no ready, result untouched.
    if (bus.annul) begin
      state_d = DIV_IDLE;
      ready_d = 1'b0;
      y_d     = y_q;
    end

    busy_d = (state_d != DIV_IDLE);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      // NOTE: the working registers are plain flops, not a memory, so they
      // are all cleared here; a reset mid-divide leaves nothing stale behind.
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      abs_b_q <= '0;
      a_raw_q <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      abs_b_q <= abs_b_d;
      a_raw_q <= a_raw_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      y_q     <= y_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.ready = ready_q;
  assign bus.y     = y_q;

endmodule : div_seq

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed corner cases plus random divides
// compared against an arithmetic reference model.
module tb_div_seq;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  logic [63:0] last_y;

  div_seq_if #(.WIDTH(32)) bus ();

  div_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if it does not match.
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // Reference: MIPS semantics via 64-bit arithmetic (truncating division,
  // remainder takes the dividend's sign); b==0 gives {a, all-ones}.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    longint la, lb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    la = s ? longint'($signed(a)) : longint'({32'd0, a});
    lb = s ? longint'($signed(b)) : longint'({32'd0, b});
    q  = la / lb;
    r  = la % lb;
    return {r[31:0], q[31:0]};
  endfunction

  // Issue one divide, scramble inputs while busy, and check latency and result.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input string tag);
    int          lat;
    bit          got;
    logic [63:0] exp;
    lat = (b == 32'd0) ? 1 : 33;
    exp = ref_div(a, b, s);
    @(negedge clk);
    bus.a = a; bus.b = b; bus.sign = s; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = (lat > 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    bus.a = $urandom; bus.b = $urandom; bus.sign = 1'($urandom_range(0, 1));
    check({tag, " busy_after_accept"}, 64'(bus.busy), 64'd1);
    got = 1'b0;
    for (int n = 1; n <= 40 && !got; n++) begin
      @(negedge clk);
      if (bus.ready) begin
        got = 1'b1;
        check({tag, " latency"}, 64'(n), 64'(lat));
        check({tag, " y"}, bus.y, exp);
        check({tag, " busy_at_ready"}, 64'(bus.busy), 64'd0);
      end else if (n == lat - 1) begin
        check({tag, " busy_before_ready"}, 64'(bus.busy), 64'd1);
      end
      bus.start = (n < lat - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.a = $urandom; bus.b = $urandom;
    end
    if (!got) check({tag, " ready_timeout"}, 64'd0, 64'd1);
    last_y = exp;
    @(negedge clk);
    check({tag, " ready_one_cycle"}, 64'(bus.ready), 64'd0);
    check({tag, " y_hold"}, bus.y, exp);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    bit          seen;
    n_cmp = 0; n_bad = 0; last_y = '0;
    bus.a = '0; bus.b = '0; bus.sign = 1'b0; bus.start = 1'b0; bus.annul = 1'b0;
    rst = 1'b0;
    #23;
    check("reset busy",  64'(bus.busy),  64'd0);
    check("reset ready", 64'(bus.ready), 64'd0);
    check("reset y",     bus.y,          64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Directed cases.
    run_div(32'd100, 32'd7, 1'b0, "u100_7");
    check("u100_7 const", last_y, 64'h00000002_0000000E);
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, "s_m7_2");
    check("s_m7_2 const", last_y, 64'hFFFFFFFF_FFFFFFFD);
    run_div(32'hFFFF_FFF9, 32'd2, 1'b0, "u_big_2");
    check("u_big_2 const", last_y, 64'h00000001_7FFFFFFC);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "s_ovf");
    check("s_ovf const", last_y, 64'h00000000_80000000);
    run_div(32'h1234_5678, 32'd0, 1'b0, "div0_u");
    run_div(32'h1234_5678, 32'd0, 1'b1, "div0_s");
    check("div0 const", last_y, 64'h12345678_FFFFFFFF);
    run_div(32'd9, 32'd3, 1'b0, "prior");

    // Flush at iteration 10: no ready, y keeps the prior result.
    @(negedge clk);
    bus.a = 32'd100; bus.b = 32'd7; bus.sign = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    bus.annul = 1'b1;
    @(negedge clk);
    bus.annul = 1'b0;
    check("annul busy", 64'(bus.busy), 64'd0);
    check("annul y",    bus.y,         last_y);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.ready) seen = 1'b1;
    end
    check("annul no_ready", 64'(seen), 64'd0);

    // start together with annul in IDLE is not accepted.
    bus.a = 32'd50; bus.b = 32'd5; bus.start = 1'b1; bus.annul = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.annul = 1'b0;
    check("start_annul busy", 64'(bus.busy), 64'd0);
    run_div(32'd9, 32'd3, 1'b0, "after_annul");
    check("after_annul const", last_y, 64'h00000000_00000003);

    // Asynchronous reset in the middle of an iteration.
    @(negedge clk);
    bus.a = 32'd100; bus.b = 32'd7; bus.sign = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst busy",  64'(bus.busy),  64'd0);
    check("async_rst ready", 64'(bus.ready), 64'd0);
    check("async_rst y",     bus.y,          64'd0);
    @(negedge clk);
    rst = 1'b1;
    run_div(32'd15, 32'd4, 1'b0, "after_rst");
    check("after_rst const", last_y, 64'h00000003_00000003);

    // Random divides with biased corner operands.
    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = 32'hFFFF_FFFF;
        3: ra = 32'h8000_0000;
        default: ;
      endcase
      run_div(ra, rb, rs, $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_div_seq
